// File: rtl/load_store_unit.sv
// Byte-serial load/store controller: turns one 32-bit request into little-endian
// byte beats on a single-port, 1-cycle-latency data memory.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     mem_wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [7:0]               mem_data_o,
  input  logic [7:0]               mem_data_i
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | one memory beat per cycle, base+k
  // DRAIN | load only: wait for the final read byte
  // RESP  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [1:0]               beat_q;
  logic [1:0]               last_q;
  logic [1:0]               size_q;
  logic                     we_q;
  logic                     uns_q;
  logic [23:0]              wdata_q;
  logic [23:0]              ld_buf_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [7:0]               mem_data_q;
  logic [31:0]              rdata_q;

  logic                     accept;
  logic                     beat_last;
  logic [31:0]              ld_full;
  logic [31:0]              ld_result;

  assign beat_last   = (beat_q == last_q);
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign rsp_rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_wr_en_o = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_wr_en_o = we_q;
        if (beat_last) state_d = we_q ? RESP : DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The last byte arrives on mem_data_i during DRAIN and is merged combinationally.
  always_comb begin
    ld_full = {8'h00, ld_buf_q};
    ld_full[{last_q, 3'b000} +: 8] = mem_data_i;
    case (size_q)
      2'b00:   ld_result = uns_q ? {24'h0, ld_full[7:0]}  : {{24{ld_full[7]}},  ld_full[7:0]};
      2'b01:   ld_result = uns_q ? {16'h0, ld_full[15:0]} : {{16{ld_full[15]}}, ld_full[15:0]};
      default: ld_result = ld_full;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q     <= 2'd0;
      last_q     <= 2'd0;
      size_q     <= 2'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= 24'h0;
      ld_buf_q   <= 24'h0;
      mem_addr_q <= '0;
      mem_data_q <= 8'h00;
      rdata_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            beat_q     <= 2'd0;
            size_q     <= req_size_i;
            we_q       <= req_we_i;
            uns_q      <= req_unsigned_i;
            wdata_q    <= req_wdata_i[31:8];
            mem_addr_q <= req_addr_i;
            if (req_we_i) mem_data_q <= req_wdata_i[7:0];
            case (req_size_i)
              2'b00:   last_q <= 2'd0;
              2'b01:   last_q <= 2'd1;
              default: last_q <= 2'd3;
            endcase
          end
        end
        ISSUE: begin
          // Read data for beat k-1 is on mem_data_i while beat k is issued.
          if (!we_q) begin
            case (beat_q)
              2'd1:    ld_buf_q[7:0]   <= mem_data_i;
              2'd2:    ld_buf_q[15:8]  <= mem_data_i;
              2'd3:    ld_buf_q[23:16] <= mem_data_i;
              default: ;
            endcase
          end
          if (!beat_last) begin
            beat_q     <= beat_q + 2'd1;
            mem_addr_q <= mem_addr_q + ADDR_ONE;
            if (we_q) begin
              mem_data_q <= wdata_q[7:0];
              wdata_q    <= {8'h00, wdata_q[23:8]};
            end
          end else if (we_q) begin
            rdata_q <= 32'h0;
          end
        end
        DRAIN: rdata_q <= ld_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory
// (synchronous write, 1-cycle registered read).
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [7:0]  req_addr_i = 8'h00;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_wr_en_o;
  logic [7:0]  mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;

  logic [7:0]  mem [256];
  logic        mem_init = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int wr_viol = 0;
  int rsp_seen = 0;
  logic ld_window = 1'b0;

  load_store_unit #(.ADDRESS_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hC3;
    end else if (mem_wr_en_o) begin
      mem[mem_addr_o] <= mem_data_o;
    end
    mem_data_i <= mem[mem_addr_o];
  end

  always @(negedge clk_i) begin
    if (ld_window && mem_wr_en_o) wr_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int lat;
    lat = 99;
    @(negedge clk_i);
    chk({tag, " ready"}, {31'h0, req_ready_o}, 32'h1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk_i);
    ld_window = !we;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (c == 1) req_valid_i = 1'b0;
      if (rsp_valid_o) begin
        lat = c;
        break;
      end
    end
    ld_window = 1'b0;
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, rsp_rdata_o, exp_rdata);
    @(negedge clk_i);
    chk({tag, " pulse/ready"}, {30'h0, rsp_valid_o, req_ready_o}, 32'h1);
    chk({tag, " hold"}, rsp_rdata_o, exp_rdata);
  endtask

  initial begin
    int rsp_c;
    int rdy_c;
    logic [31:0] bp_rd;

    #2;
    chk("rst ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst outs", {rsp_valid_o, mem_wr_en_o, 6'h0, mem_addr_o, mem_data_o, 8'h0}, 32'h0);
    chk("rst rdata", rsp_rdata_o, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    mem_init = 1'b0;
    rst_i    = 1'b0;

    do_req("st w", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 5);
    chk("mem w", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
    do_req("ld w", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 6);

    do_req("st b", 1'b1, 2'b00, 1'b0, 8'h20, 32'h12345680, 32'h0, 2);
    chk("mem b", {24'h0, mem[8'h20]}, 32'h80);
    chk("mem b+1", {24'h0, mem[8'h21]}, 32'hC3);
    do_req("ld bs", 1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 32'hFFFFFF80, 3);
    do_req("ld bu", 1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 32'h00000080, 3);

    do_req("st h wrap", 1'b1, 2'b01, 1'b0, 8'hFF, 32'hAAAA8001, 32'h0, 3);
    chk("mem h wrap", {16'h0, mem[8'h00], mem[8'hFF]}, 32'h8001);
    chk("mem h wrap+2", {24'h0, mem[8'h01]}, 32'hC3);
    do_req("ld hs", 1'b0, 2'b01, 1'b0, 8'hFF, 32'h0, 32'hFFFF8001, 4);
    do_req("ld hu", 1'b0, 2'b01, 1'b1, 8'hFF, 32'h0, 32'h00008001, 4);

    // Back-pressure: a byte load followed immediately by a held store request.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 8'h20; req_wdata_i = 32'h0;
    @(posedge clk_i);
    ld_window = 1'b1;
    #1;
    req_we_i = 1'b1; req_addr_i = 8'h30; req_wdata_i = 32'h0000005A;
    rsp_c = 0; rdy_c = 99; bp_rd = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o && rsp_c == 0) begin
        rsp_c = c;
        bp_rd = rsp_rdata_o;
      end
      if (req_ready_o) begin
        rdy_c = c;
        break;
      end
    end
    ld_window = 1'b0;
    chk("bp ld lat", 32'(rsp_c), 32'd3);
    chk("bp ld rdata", bp_rd, 32'hFFFFFF80);
    chk("bp ready cyc", 32'(rdy_c), 32'd4);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("bp st beat", {23'h0, mem_wr_en_o, mem_addr_o}, {23'h0, 1'b1, 8'h30});
    chk("bp st data", {24'h0, mem_data_o}, 32'h5A);
    @(negedge clk_i);
    chk("bp st rsp", {30'h0, rsp_valid_o, mem_wr_en_o}, 32'h2);
    chk("bp st mem", {24'h0, mem[8'h30]}, 32'h5A);

    do_req("st w11", 1'b1, 2'b11, 1'b0, 8'h50, 32'h80A0B0C0, 32'h0, 5);
    do_req("ld w uns", 1'b0, 2'b10, 1'b1, 8'h50, 32'h0, 32'h80A0B0C0, 6);
    chk("no wr in loads", 32'(wr_viol), 32'd0);

    // Reset during cycle 2 of a word store.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10;
    req_unsigned_i = 1'b0; req_addr_i = 8'h40; req_wdata_i = 32'h11223344;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("rst st beat0", {15'h0, mem_wr_en_o, mem_addr_o, mem_data_o}, {15'h0, 1'b1, 8'h40, 8'h44});
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort ready", {31'h0, req_ready_o}, 32'h1);
    chk("abort outs", {rsp_valid_o, mem_wr_en_o, 6'h0, mem_addr_o, mem_data_o, 8'h0}, 32'h0);
    chk("abort rdata", rsp_rdata_o, 32'h0);
    rsp_seen = 0;
    repeat (2) begin
      @(negedge clk_i);
      if (rsp_valid_o) rsp_seen++;
    end
    rst_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (rsp_valid_o) rsp_seen++;
    end
    chk("abort no rsp", 32'(rsp_seen), 32'd0);
    chk("abort mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hC3C3C344);
    do_req("ld after rst", 1'b0, 2'b00, 1'b1, 8'h40, 32'h0, 32'h00000044, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Requester-side controller for the byte-wide synchronous data memory. It accepts one 32-bit load/store request at a time from the datapath and serialises it into little-endian byte accesses on the memory's single-address, write-enable-only port. Loads are zero- or sign-extended, and completion is signalled with a one-cycle response pulse. It sits between the execute/memory stage and the data memory.

## Interface
- ADDRESS_WIDTH, 8, byte-address width of the data memory; memory data width is fixed at 8.
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept a request; high only in IDLE.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned_i  input  1  load only: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  input  ADDRESS_WIDTH  base byte address; no alignment requirement.
- req_wdata_i  input  32  store data; the low n bytes are used.
- rsp_valid_o  output  1  one-cycle completion pulse for loads and stores.
- rsp_rdata_o  output  32  extended load result; 0 after a store.
- mem_wr_en_o  output  1  drives the memory write enable.
- mem_addr_o  output  ADDRESS_WIDTH  drives the memory address.
- mem_data_o  output  8  drives the memory write data.
- mem_data_i  input  8  memory read data, registered by the memory with 1-cycle latency.

## Operation
- Byte count: n = 1, 2 or 4 from req_size_i.
- Little-endian. Beat k accesses address base+k modulo 2^ADDRESS_WIDTH, so addresses wrap past the top of memory.
- Handshake: a request is accepted on the rising edge where req_valid_i && req_ready_o. The unit latches addr, size, we, unsigned and wdata. Request inputs are ignored while busy.
- FSM states:
  - IDLE: req_ready_o=1. On accept, go to ISSUE with beat counter = 0.
  - ISSUE: one beat per cycle.
    - mem_addr_o = base+k.
    - Store: mem_wr_en_o=1, mem_data_o = wdata byte k.
    - Load: mem_wr_en_o=0.
    - After beat n-1: a store goes to RESP, a load goes to DRAIN.
  - DRAIN (load only): mem_wr_en_o=0. Captures the final byte, then goes to RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Load capture: the byte for beat k is sampled from mem_data_i on the edge that ends the cycle after beat k was issued. Captures for beats 0..n-2 occur in ISSUE; the capture for beat n-1 occurs in DRAIN.
- Load result:
  - Assembled bytes fill bits [8n-1:0].
  - Bits [31:8n] are copies of bit 8n-1 if signed, otherwise 0.
  - A word load ignores req_unsigned_i.
- Store result: rsp_rdata_o = 0 in RESP.
- Hold behaviour: rsp_rdata_o holds its value after RESP until the next response. mem_addr_o and mem_data_o hold their last driven values outside ISSUE. mem_wr_en_o is 0 in every state except ISSUE during a store.

## Timing
- Reset (asynchronous, immediate): state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, mem_wr_en_o=0, mem_addr_o=0, mem_data_o=0, beat counter=0.
- Accept edge E0. ISSUE occupies cycles 1..n after E0.
- Store: RESP in cycle n+1; back in IDLE (ready=1) in cycle n+2. Back-to-back throughput is n+2 cycles per store.
- Load: DRAIN in cycle n+1, RESP in cycle n+2; ready again in cycle n+3.
- Latency summary: byte load rsp at cycle 3, word load at cycle 6, byte store at cycle 2, word store at cycle 5.
- A request held valid across RESP is not accepted until the IDLE cycle. Only one request is ever in flight.
- Reset mid-operation: the FSM aborts immediately with no response. Store beats already written remain in memory; no further beats are issued.
- Wrap-around: base=2^ADDRESS_WIDTH-1 with a half access touches the top byte then address 0.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10.
  - Memory holds 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE.
  - rsp_rdata_o=0xDEADBEEF with rsp_valid_o at cycle 6 after accept.
- Byte 0x80 at 0x20, signed byte load -> 0xFFFFFF80. Unsigned byte load -> 0x00000080. rsp_valid_o is a single-cycle pulse each time.
- Half store 0x8001 at 0xFF (ADDRESS_WIDTH=8).
  - Memory holds 0xFF=01, 0x00=80.
  - Signed half load at 0xFF -> 0xFFFF8001.
- Back-pressure: req_valid_i held high with two queued requests. The second is accepted only when req_ready_o=1, and mem_wr_en_o never asserts during load/DRAIN/RESP cycles.
- Assert rst_i in cycle 2 of a word store of 0x11223344 at 0x40.
  - Outputs reach reset values without waiting for a clock edge; no rsp_valid_o.
  - Only byte 0x44 at 0x40 was written; 0x41..0x43 remain unchanged.
